// File: rtl/dm_arbiter_if.sv
// Signal bundle between the MEM stage, the debug/loader port, dm_4k and dm_arbiter.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface dm_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_mode;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_misalign;

    logic        dbg_req;
    logic        dbg_we;
    logic [11:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [1:0]  dbg_mode;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_misalign;

    logic [11:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_wr;
    logic [1:0]  dm_mode;
    logic [31:0] dm_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mode,
        output cpu_stall, cpu_rdata, cpu_misalign,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_mode,
        output dbg_ack, dbg_rdata, dbg_misalign,
        output dm_addr, dm_din, dm_wr, dm_mode,
        input  dm_dout
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mode,
        input  cpu_stall, cpu_rdata, cpu_misalign,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_mode,
        input  dbg_ack, dbg_rdata, dbg_misalign,
        input  dm_addr, dm_din, dm_wr, dm_mode,
        output dm_dout
    );
endinterface

// File: rtl/dm_arbiter.sv
// Shares dm_4k between the MEM stage (priority) and a debug/loader port, with a
// starvation limit on the debug side and misaligned accesses blocked before memory.
module dm_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic         clk,
    input logic         rst,
    dm_arbiter_if.slave bus
);
    // Access-size encodings shared with declarations.v; any other value is a word.
    localparam logic [1:0] MEM_OP_BYTE = 2'b01;
    localparam logic [1:0] MEM_OP_HALF = 2'b10;

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_WAIT = 2'd1;
    localparam logic [1:0] D_ACK  = 2'd2;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  dbg_state_q, dbg_state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0] dbg_rdata_q;
    logic        dbg_misalign_q;
    logic        dbg_win, cpu_win, cpu_mis, dbg_mis;

    function automatic logic misaligned(input logic [11:0] addr, input logic [1:0] mode);
        if (mode == MEM_OP_BYTE) return 1'b0;
        if (mode == MEM_OP_HALF) return addr[0];
        return |addr[1:0];
    endfunction

    always_comb begin
        cpu_mis = misaligned(bus.cpu_addr, bus.cpu_mode);
        dbg_mis = misaligned(bus.dbg_addr, bus.dbg_mode);
        dbg_win = (dbg_state_q == D_WAIT) && ((starve_cnt_q == STARVE_LIM) || !bus.cpu_req);
        cpu_win = bus.cpu_req && !dbg_win;
    end

    always_comb begin
        bus.dm_addr = '0;
        bus.dm_din  = '0;
        bus.dm_mode = '0;
        bus.dm_wr   = 1'b0;
        if (dbg_win) begin
            bus.dm_addr = bus.dbg_addr;
            bus.dm_din  = bus.dbg_wdata;
            bus.dm_mode = bus.dbg_mode;
            bus.dm_wr   = bus.dbg_we && !dbg_mis;
        end else if (cpu_win) begin
            bus.dm_addr = bus.cpu_addr;
            bus.dm_din  = bus.cpu_wdata;
            bus.dm_mode = bus.cpu_mode;
            bus.dm_wr   = bus.cpu_we && !cpu_mis;
        end
    end

    assign bus.cpu_stall    = bus.cpu_req && dbg_win;
    assign bus.cpu_misalign = cpu_win && cpu_mis;
    assign bus.cpu_rdata    = bus.dm_dout;

    assign bus.dbg_ack      = (dbg_state_q == D_ACK);
    assign bus.dbg_rdata    = dbg_rdata_q;
    assign bus.dbg_misalign = dbg_misalign_q;

    always_comb begin
        dbg_state_d  = dbg_state_q;
        starve_cnt_d = starve_cnt_q;
        case (dbg_state_q)
            D_IDLE: begin
                starve_cnt_d = '0;
                if (bus.dbg_req) dbg_state_d = D_WAIT;
            end
            D_WAIT: begin
                if (dbg_win) begin
                    dbg_state_d  = D_ACK;
                    starve_cnt_d = '0;
                end else if (cpu_win && (starve_cnt_q != STARVE_LIM)) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end
            // dbg_req is deliberately ignored here so the requester can drop it.
            D_ACK: begin
                dbg_state_d  = D_IDLE;
                starve_cnt_d = '0;
            end
            default: begin
                dbg_state_d  = D_IDLE;
                starve_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_state_q    <= D_IDLE;
            starve_cnt_q   <= '0;
            dbg_rdata_q    <= '0;
            dbg_misalign_q <= 1'b0;
        end else begin
            dbg_state_q  <= dbg_state_d;
            starve_cnt_q <= starve_cnt_d;
            if (dbg_win) begin
                dbg_rdata_q    <= bus.dm_dout;
                dbg_misalign_q <= dbg_mis;
            end
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a byte-level memory model predicts every cycle,
// a negedge monitor compares the DUT against the queued expectations.
module tb_dm_arbiter;
    localparam int unsigned STARVE_MAX = 4;
    localparam int          SMAX       = int'(STARVE_MAX);
    localparam logic [1:0]  MODE_WORD  = 2'b00;
    localparam logic [1:0]  MODE_BYTE  = 2'b01;
    localparam logic [1:0]  MODE_HALF  = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_arbiter_if bus ();

    dm_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural dm_4k seen by the DUT: little-endian bytes, word-wide combinational read.
    logic [7:0] env_mem [4096];
    assign bus.dm_dout = {env_mem[{bus.dm_addr[11:2], 2'd3}], env_mem[{bus.dm_addr[11:2], 2'd2}],
                          env_mem[{bus.dm_addr[11:2], 2'd1}], env_mem[{bus.dm_addr[11:2], 2'd0}]};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) env_mem[i] <= 8'h00;
        end else if (bus.dm_wr) begin
            if (bus.dm_mode == MODE_BYTE) begin
                env_mem[bus.dm_addr] <= bus.dm_din[7:0];
            end else if (bus.dm_mode == MODE_HALF) begin
                env_mem[{bus.dm_addr[11:1], 1'b0}] <= bus.dm_din[7:0];
                env_mem[{bus.dm_addr[11:1], 1'b1}] <= bus.dm_din[15:8];
            end else begin
                for (int b = 0; b < 4; b++)
                    env_mem[{bus.dm_addr[11:2], 2'(b)}] <= bus.dm_din[8*b +: 8];
            end
        end
    end

    // Reference model state
    logic [7:0] ref_mem [4096];
    int m_phase = 0;  // 0: no dbg access, 1: dbg waiting for a slot, 2: ack cycle
    int m_lost  = 0;

    typedef struct {
        bit          req;
        bit          stall;
        bit          mis;
        bit          chk_rd;
        logic [31:0] rdata;
        bit          wr;
    } cyc_exp_t;

    typedef struct {
        int          ack_cyc;
        logic [31:0] rdata;
        bit          mis;
    } dbg_exp_t;

    cyc_exp_t cyc_q[$];
    dbg_exp_t dbg_q[$];

    // Stimulus values applied on the next tick
    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
    logic [11:0] c_addr = 0, d_addr = 0;
    logic [31:0] c_wdata = 0, d_wdata = 0;
    logic [1:0]  c_mode = 0, d_mode = 0;

    function automatic bit mis_of(input logic [11:0] a, input logic [1:0] m);
        if (m == MODE_BYTE) return 1'b0;
        if (m == MODE_HALF) return a[0] == 1'b1;
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] ref_word(input logic [11:0] a);
        int base;
        base = int'({a[11:2], 2'b00});
        return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
    endfunction

    function automatic logic [31:0] env_word(input logic [11:0] a);
        int base;
        base = int'({a[11:2], 2'b00});
        return {env_mem[base + 3], env_mem[base + 2], env_mem[base + 1], env_mem[base]};
    endfunction

    task automatic ref_write(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
        int base;
        if (m == MODE_BYTE) begin
            ref_mem[a] = d[7:0];
        end else if (m == MODE_HALF) begin
            base = int'(a) & ~1;
            ref_mem[base]     = d[7:0];
            ref_mem[base + 1] = d[15:8];
        end else begin
            base = int'(a) & ~3;
            for (int b = 0; b < 4; b++) ref_mem[base + b] = d[8*b +: 8];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: apply stimulus, predict this cycle's outcome, advance the model.
    task automatic tick();
        cyc_exp_t e;
        dbg_exp_t de;
        bit dwin, cwin, cmis, dmis;
        @(posedge clk);
        #1;
        bus.cpu_req = c_req; bus.cpu_we = c_we; bus.cpu_addr = c_addr;
        bus.cpu_wdata = c_wdata; bus.cpu_mode = c_mode;
        bus.dbg_req = d_req; bus.dbg_we = d_we; bus.dbg_addr = d_addr;
        bus.dbg_wdata = d_wdata; bus.dbg_mode = d_mode;
        dwin = (m_phase == 1) && (m_lost >= SMAX || !c_req);
        cwin = c_req && !dwin;
        cmis = mis_of(c_addr, c_mode);
        dmis = mis_of(d_addr, d_mode);
        e.req    = c_req;
        e.stall  = c_req && dwin;
        e.mis    = cwin && cmis;
        e.chk_rd = cwin && !c_we && !cmis;
        e.rdata  = ref_word(c_addr);
        e.wr     = (dwin && d_we && !dmis) || (cwin && c_we && !cmis);
        cyc_q.push_back(e);
        if (dwin) begin
            de.ack_cyc = cyc + 1;
            de.rdata   = ref_word(d_addr);
            de.mis     = dmis;
            dbg_q.push_back(de);
            if (d_we && !dmis) ref_write(d_addr, d_mode, d_wdata);
        end
        if (cwin && c_we && !cmis) ref_write(c_addr, c_mode, c_wdata);
        case (m_phase)
            0: if (d_req) begin m_phase = 1; m_lost = 0; end
            1: if (dwin) m_phase = 2; else if (m_lost < SMAX) m_lost++;
            default: m_phase = 0;
        endcase
    endtask

    always @(negedge clk) begin
        cyc_exp_t e;
        dbg_exp_t de;
        if (mon_en) begin
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                if (e.req) begin
                    check("cpu_stall", 32'(bus.cpu_stall), 32'(e.stall));
                    check("cpu_misalign", 32'(bus.cpu_misalign), 32'(e.mis));
                    if (e.chk_rd) check("cpu_rdata", bus.cpu_rdata, e.rdata);
                end
                check("dm_wr", 32'(bus.dm_wr), 32'(e.wr));
            end
            if (bus.dbg_ack) begin
                if (dbg_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dbg_ack: got unexpected pulse required none (cycle %0d)", cyc);
                end else begin
                    de = dbg_q.pop_front();
                    check("dbg_ack_cycle", 32'(cyc), 32'(de.ack_cyc));
                    check("dbg_rdata", bus.dbg_rdata, de.rdata);
                    check("dbg_misalign", 32'(bus.dbg_misalign), 32'(de.mis));
                end
            end
        end
    end

    task automatic dbg_access(input bit we, input logic [11:0] a, input logic [31:0] d,
                              input logic [1:0] m, input bit keep_req);
        int n;
        d_req = 1; d_we = we; d_addr = a; d_wdata = d; d_mode = m;
        n = 0;
        do begin
            tick();
            n++;
        end while (m_phase != 2 && n < 20);
        if (m_phase != 2) begin
            n_tests++;
            n_fail++;
            $display("FAIL dbg_access: got no grant in %0d cycles required grant", n);
        end
        d_req = keep_req;
        tick();
        #3;
        check("dbg_ack_pulse", 32'(bus.dbg_ack), 32'd1);
    endtask

    task automatic new_dbg();
        d_we    = 1'($urandom);
        d_mode  = 2'($urandom_range(0, 3));
        d_addr  = 12'($urandom_range(0, 255));
        d_wdata = $urandom;
        if ($urandom_range(0, 3) != 0) d_addr = d_addr & ((d_mode == MODE_HALF) ? 12'hFFE :
                                                          (d_mode == MODE_BYTE) ? 12'hFFF : 12'hFFC);
    endtask

    logic [31:0] snap;
    int          pct;
    int          guard;

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_mode = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0; bus.dbg_mode = 0;
        repeat (2) @(posedge clk);
        #3;
        check("reset dbg_ack", 32'(bus.dbg_ack), 32'd0);
        check("reset dbg_rdata", bus.dbg_rdata, 32'd0);
        check("reset dbg_misalign", 32'(bus.dbg_misalign), 32'd0);
        check("reset starve_cnt", 32'(dut.starve_cnt_q), 32'd0);
        check("idle dm_wr", 32'(bus.dm_wr), 32'd0);
        check("idle dm_addr", 32'(bus.dm_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        mem_clr = 0;
        mon_en = 1;

        // cpu only: store then load a word
        c_req = 1; c_we = 1; c_addr = 12'h010; c_wdata = 32'h12345678; c_mode = MODE_WORD;
        tick(); #3;
        check("cpu store stall", 32'(bus.cpu_stall), 32'd0);
        c_we = 0;
        tick(); #3;
        check("cpu load stall", 32'(bus.cpu_stall), 32'd0);
        check("cpu load data", bus.cpu_rdata, 32'h12345678);
        c_req = 0;

        // dbg only: byte write then word read
        dbg_access(1'b1, 12'h013, 32'h000000AB, MODE_BYTE, 1'b0);
        dbg_access(1'b0, 12'h010, 32'h0, MODE_WORD, 1'b0);
        check("dbg read data", bus.dbg_rdata, 32'hAB345678);

        // Contention: cpu holds its request, dbg must win on the STARVE_MAX+1-th wait cycle
        c_req = 1; c_we = 0; c_addr = 12'h040; c_mode = MODE_WORD;
        d_req = 1; d_we = 0; d_addr = 12'h010; d_mode = MODE_WORD;
        for (int i = 0; i <= SMAX + 1; i++) begin
            tick(); #3;
            check("contention stall", 32'(bus.cpu_stall), 32'(i == SMAX + 1));
        end
        d_req = 0;
        tick(); #3;
        check("contention ack", 32'(bus.dbg_ack), 32'd1);
        check("contention rdata", bus.dbg_rdata, 32'hAB345678);
        check("starve_cnt after win", 32'(dut.starve_cnt_q), 32'd0);

        // Misalignment on both ports
        snap = ref_word(12'h020);
        c_req = 1; c_we = 1; c_addr = 12'h021; c_wdata = 32'h0000FFFF; c_mode = MODE_HALF;
        tick(); #3;
        check("cpu misalign flag", 32'(bus.cpu_misalign), 32'd1);
        check("cpu misalign dm_wr", 32'(bus.dm_wr), 32'd0);
        c_we = 0; c_addr = 12'h020; c_mode = MODE_WORD;
        tick(); #3;
        check("mem after misaligned store", bus.cpu_rdata, snap);
        c_req = 0;
        dbg_access(1'b0, 12'h022, 32'h0, MODE_WORD, 1'b0);
        check("dbg misalign flag", 32'(bus.dbg_misalign), 32'd1);

        // Back-to-back: request held through the ack cycle
        dbg_access(1'b1, 12'h030, 32'h0000005A, MODE_BYTE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            d_req = (i < 2);
            tick(); #3;
            check("back-to-back ack", 32'(bus.dbg_ack), 32'(i == 2));
        end

        // Randomised traffic
        for (int seg = 0; seg < 3; seg++) begin
            pct = (seg == 1) ? 95 : 50;
            for (int n = 0; n < 150; n++) begin
                c_req   = ($urandom_range(0, 99) < pct);
                c_we    = 1'($urandom);
                c_mode  = 2'($urandom_range(0, 3));
                c_addr  = 12'($urandom_range(0, 255));
                c_wdata = $urandom;
                if ($urandom_range(0, 3) != 0) c_addr = {c_addr[11:2], 2'b00};
                if (m_phase == 0 && !d_req && $urandom_range(0, 3) == 0) begin
                    new_dbg();
                    d_req = 1;
                end else if (m_phase == 2) begin
                    case ($urandom_range(0, 2))
                        0:       d_req = 0;
                        1:       new_dbg();
                        default: ;
                    endcase
                end
                tick();
            end
        end

        // Drain any outstanding dbg access
        c_req = 0;
        guard = 0;
        while ((m_phase != 0 || d_req) && guard < 50) begin
            if (m_phase == 2) d_req = 0;
            tick();
            guard++;
        end
        tick();
        tick();
        #3;
        check("dbg queue drained", 32'(dbg_q.size()), 32'd0);

        // Reset while dbg is waiting and cpu is winning
        snap = env_word(12'h200);
        c_req = 1; c_we = 0; c_addr = 12'h100; c_mode = MODE_WORD;
        d_req = 1; d_we = 1; d_addr = 12'h200; d_wdata = 32'hDEADBEEF; d_mode = MODE_WORD;
        tick();
        tick();
        #2;
        mon_en = 0;
        rst = 1;
        bus.cpu_req = 0;
        bus.dbg_req = 0;
        #2;
        check("rst starve_cnt", 32'(dut.starve_cnt_q), 32'd0);
        check("rst dbg_ack", 32'(bus.dbg_ack), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        c_req = 0; d_req = 0;
        m_phase = 0; m_lost = 0;
        cyc_q.delete();
        dbg_q.delete();
        mon_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick(); #3;
            check("post-reset dbg_ack", 32'(bus.dbg_ack), 32'd0);
        end
        check("post-reset no dbg write", env_word(12'h200), snap);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single data memory (dm_4k) between the pipeline MEM stage (cpu port) and a debug/loader port (dbg port).
- The cpu port has priority. A starvation counter guarantees the dbg port a slot.
- Misaligned accesses are blocked here, before they reach the memory.
- Sits between the EX/MEM pipeline register and dm_4k. Drives dm_4k's addr/din/DMWr/mode and steers its dout back to the winner.

Parameters:
- STARVE_MAX, 4: cycles the dbg port may lose arbitration before it is forced to win (1..15).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  MEM stage has a load/store this cycle.
- cpu_we  in  1  store (1) / load (0).
- cpu_addr  in  12  byte address.
- cpu_wdata  in  32  store data.
- cpu_mode  in  2  access size; `MEM_op_byte / `MEM_op_half from declarations.v, any other value is word.
- cpu_stall  out  1  cpu access not performed this cycle; pipeline must hold.
- cpu_rdata  out  32  load data; combinational, valid when cpu_req && !cpu_stall.
- cpu_misalign  out  1  cpu access is misaligned; access suppressed.
- dbg_req  in  1  debug request; held stable until dbg_ack.
- dbg_we  in  1  debug write/read.
- dbg_addr  in  12  debug byte address.
- dbg_wdata  in  32  debug write data.
- dbg_mode  in  2  debug access size.
- dbg_ack  out  1  one-cycle pulse; access done.
- dbg_rdata  out  32  registered read data, valid while dbg_ack=1.
- dbg_misalign  out  1  registered with dbg_ack; debug access was misaligned and suppressed.
- dm_addr  out  12  to dm_4k addr.
- dm_din  out  32  to dm_4k din.
- dm_wr  out  1  to dm_4k DMWr.
- dm_mode  out  2  to dm_4k mode.
- dm_dout  in  32  from dm_4k dout.

Behaviour:
- Misalignment:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - byte is never misaligned.
- Grant, computed combinationally each cycle from state and requests:
  - dbg wins if dbg_state==D_WAIT && (starve_cnt==STARVE_MAX || !cpu_req).
  - Otherwise cpu wins if cpu_req.
  - Otherwise no grant.
- Mux outputs:
  - dm_addr/dm_din/dm_mode follow the winner; all zero when there is no winner.
  - dm_wr = winner_we && !winner_misalign. A misaligned store never writes memory.
- cpu side:
  - cpu_stall = cpu_req && dbg wins.
  - cpu_misalign = cpu_req && !cpu_stall && misaligned(cpu_addr, cpu_mode).
  - cpu_rdata = dm_dout, passed through with no added latency.
- dbg FSM, 2-bit state:
  - D_IDLE: dbg_req=1 -> D_WAIT.
  - D_WAIT: when dbg wins, capture dm_dout into dbg_rdata and misalign into dbg_misalign, then go to D_ACK. The access is performed in this same cycle.
  - D_ACK: dbg_ack=1 for exactly this one cycle, then go to D_IDLE. dbg_req is ignored in D_ACK so the requester can drop it. A req still high in D_IDLE starts a new access.
- starve_cnt (4-bit):
  - Increments each cycle in D_WAIT in which cpu wins.
  - Saturates at STARVE_MAX.
  - Clears when dbg wins.
  - Holds at 0 outside D_WAIT.
- Simultaneous requests with starve_cnt<STARVE_MAX: cpu wins, dbg waits.
- Worst-case dbg latency from req to ack: STARVE_MAX+2 cycles.
- Reset values (async, any time, including mid-access):
  - dbg_state=D_IDLE, starve_cnt=0, dbg_ack=0, dbg_rdata=0, dbg_misalign=0.
  - Combinational outputs follow inputs. A dbg access interrupted before its D_WAIT grant cycle performs no write.

Test Plan:
- cpu only: store word 0x12345678 at 0x010, then load word at 0x010 -> cpu_stall=0 both cycles; cpu_rdata=0x12345678.
- dbg only: write byte 0xAB at 0x013, then read word at 0x010 -> dbg_ack 2 cycles after each req; dbg_rdata=0xAB345678.
- Contention: cpu_req held high continuously, dbg read raised (STARVE_MAX=4) -> cpu wins 4 cycles; 5th cycle cpu_stall=1 and dbg wins; dbg_ack next cycle; starve_cnt=0 afterwards.
- Misalignment: cpu half store at 0x021 with data 0xFFFF -> cpu_misalign=1, dm_wr=0; memory at 0x020 unchanged. dbg word read at 0x022 -> dbg_misalign=1 with dbg_ack.
- Back-to-back dbg: dbg_req held high through ack -> no access in the D_ACK cycle; a second access starts in D_IDLE, with ack 3 cycles after the first.
- Reset mid-wait: assert rst while in D_WAIT with cpu winning -> dbg_ack never pulses, starve_cnt=0, no dbg write occurs.
